// File: rtl/reg_file_module.sv
// 32 x XLEN register file with asynchronous read ports, one write port and a
// clear sequencer that zeroes x1..x(NREGS-1) after reset while holding busy.
module reg_file_module #(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int AW             = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            busy,
    output logic            wr_drop
);

    typedef enum logic {READY, CLEAR} state_t;

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    state_t          state_reg;
    logic [AW-1:0]   clr_cnt_reg;
    logic            busy_reg;
    logic            wr_drop_reg;
    logic            wr_en;

    // x0 is never stored; it is synthesised as a constant zero on reads
    logic [XLEN-1:0] mem_reg [1:NREGS-1];

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    assign wr_en = WE3 & ~busy_reg & addr_ok(A3);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_reg <= 1'b0;
            clr_cnt_reg <= AW'(1);
            if (CLEAR_ON_RESET) begin
                state_reg <= CLEAR;
                busy_reg  <= 1'b1;
            end else begin
                state_reg <= READY;
                busy_reg  <= 1'b0;
            end
        end else begin
            wr_drop_reg <= WE3 & busy_reg & (A3 != '0);
            case (state_reg)
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == LAST) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= READY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The clear sequencer owns the write port while busy; user writes are dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem_reg[clr_cnt_reg] <= '0;
            end else if (wr_en) begin
                mem_reg[A3] <= WD3;
            end
        end
    end

    // No write bypass: a same-cycle read of A3 sees the pre-edge contents
    assign RD1      = (!busy_reg && addr_ok(A1))       ? mem_reg[A1]       : '0;
    assign RD2      = (!busy_reg && addr_ok(A2))       ? mem_reg[A2]       : '0;
    assign dbg_data = (!busy_reg && addr_ok(dbg_addr)) ? mem_reg[dbg_addr] : '0;

    assign busy    = busy_reg;
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_reg_file_module.sv
// Bench for reg_file_module: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against an array-based reference model.
module tb_reg_file_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1, A2, A3, dbg_addr;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2, dbg_data;
    logic        busy, wr_drop;

    int checks = 0;
    int errors = 0;

    reg_file_module dut (
        .clk(clk), .rst(rst),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(RD1), .RD2(RD2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    // Reference model: registers as a plain array, busy as remaining cycles
    logic [31:0] m [0:31];
    int          m_busy  = 0;
    logic        m_drop  = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        m_drop = WE3 && (m_busy > 0) && (A3 != 0) && !rst;
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
            m_busy  = 31;
            m_valid = 1'b1;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (WE3 && A3 != 0) begin
            m[A3] = WD3;
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (m_busy > 0 || a == 0) ? 32'h0 : m[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",     {31'h0, busy},    {31'h0, (m_busy > 0)});
            chk("wr_drop",  {31'h0, wr_drop}, {31'h0, m_drop});
            chk("RD1",      RD1,      m_read(A1));
            chk("RD2",      RD2,      m_read(A2));
            chk("dbg_data", dbg_data, m_read(dbg_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic count_busy(output int c);
        c = 0;
        @(negedge clk);
        while (busy === 1'b1 && c < 100) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WE3 = 1'b1; A3 = a; WD3 = d;
        step();
        WE3 = 1'b0;
        $display("write x%0d = %h", a, d);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(32 - i);
            @(negedge clk);
            chk(tag, RD1, 32'h0);
            step();
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; WE3 = 1'b0; A1 = 0; A2 = 0; A3 = 0; dbg_addr = 0; WD3 = 0;
        #2;
        step();
        rst = 1'b0;

        // 1: clear period length, then everything reads zero
        count_busy(n);
        chk("busy_len_1", 32'(n), 32'd31);
        $display("reset clear: busy cycles=%0d", n);
        step();
        sweep_zero("sweep_1");

        // 2: write x5, no bypass in the write cycle
        WE3 = 1'b1; A3 = 5; WD3 = 32'hDEADBEEF; A1 = 5; A2 = 5;
        @(negedge clk);
        chk("nobypass_RD1", RD1, 32'h0);
        step();
        WE3 = 1'b0;
        @(negedge clk);
        chk("x5_RD1", RD1, 32'hDEADBEEF);
        chk("x5_RD2", RD2, 32'hDEADBEEF);
        $display("write x5 = deadbeef, readback %h/%h", RD1, RD2);
        step();

        // 3: writes to x0 are ignored silently
        A1 = 0;
        wr(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        chk("x0_RD1", RD1, 32'h0);
        chk("x0_wr_drop", {31'h0, wr_drop}, 32'h0);
        step();

        // 4: write during clear is dropped and flagged for one cycle
        wr(5'd7, 32'h11111111);
        do_reset();
        repeat (4) step();
        wr(5'd7, 32'h12345678);
        @(negedge clk);
        chk("drop_pulse", {31'h0, wr_drop}, 32'h1);
        step();
        @(negedge clk);
        chk("drop_end", {31'h0, wr_drop}, 32'h0);
        count_busy(n);
        if (n >= 100) chk("ready_timeout_4", {31'h0, busy}, 32'h0);
        step();
        A1 = 7;
        @(negedge clk);
        chk("x7_cleared", RD1, 32'h0);
        $display("dropped write x7 during clear, x7 now %h", RD1);
        step();

        // 5: reset mid-clear restarts the full sequence
        wr(5'd3, 32'hCAFEF00D);
        do_reset();
        repeat (9) step();
        rst = 1'b1;
        @(negedge clk);
        chk("busy_in_rst", {31'h0, busy}, 32'h1);
        step();
        rst = 1'b0;
        count_busy(n);
        chk("busy_len_5", 32'(n), 32'd31);
        $display("re-reset mid clear: busy cycles=%0d", n);
        step();
        sweep_zero("sweep_5");

        // 6: extremes of the address space and simultaneous reads
        wr(5'd31, 32'hA5A5A5A5);
        wr(5'd1,  32'h5A5A5A5A);
        dbg_addr = 31; A1 = 1; A2 = 31;
        @(negedge clk);
        chk("dbg_x31", dbg_data, 32'hA5A5A5A5);
        chk("x1_RD1",  RD1,      32'h5A5A5A5A);
        chk("x31_RD2", RD2,      32'hA5A5A5A5);
        $display("dbg x31=%h RD1 x1=%h RD2 x31=%h", dbg_data, RD1, RD2);
        step();

        // Randomized traffic, occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            WE3      = $urandom_range(0, 1);
            A3       = 5'($urandom_range(0, 31));
            WD3      = $urandom;
            A1       = 5'($urandom_range(0, 31));
            A2       = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; WE3 = 1'b0;
        step();
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
